// File: rtl/elixirchip_es1_spu_sra_arbiter.sv
// Round-robin arbiter sharing one external arithmetic-right-shift unit; an ID tag pipe
// matched to the shifter latency routes results back. Optional counters: ELIXIRCHIP_SPU_SRA_ARB_STATS_EN.
module elixirchip_es1_spu_sra_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 32,
    parameter int SHIFT_BITS = $clog2(DATA_BITS),
    parameter int LATENCY    = 3,
    parameter int ID_BITS    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cke,
    input  logic [NUM_REQ-1:0]            s_valid,
    output logic [NUM_REQ-1:0]            s_ready,
    input  logic [NUM_REQ*SHIFT_BITS-1:0] s_shift,
    input  logic [NUM_REQ*DATA_BITS-1:0]  s_data,
    input  logic                          flush,
    output logic [SHIFT_BITS-1:0]         op_shift,
    output logic [DATA_BITS-1:0]          op_data,
    output logic                          op_valid,
    output logic                          op_clear,
    input  logic [DATA_BITS-1:0]          op_result,
    output logic                          rsp_valid,
    output logic [ID_BITS-1:0]            rsp_id,
    output logic [DATA_BITS-1:0]          rsp_data
`ifdef ELIXIRCHIP_SPU_SRA_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stat_grants,
    output logic [31:0]                   stat_stall
`endif
);

    logic                  any_valid;
    logic                  grant;
    logic [ID_BITS-1:0]    winner;
    logic [ID_BITS-1:0]    rr_ptr_reg;
    logic [ID_BITS-1:0]    rr_ptr_next;
    logic [SHIFT_BITS-1:0] shift_arr [NUM_REQ];
    logic [DATA_BITS-1:0]  data_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign shift_arr[gi] = s_shift[gi*SHIFT_BITS +: SHIFT_BITS];
            assign data_arr[gi]  = s_data[gi*DATA_BITS +: DATA_BITS];
            assign s_ready[gi]   = grant && (winner == ID_BITS'(gi));
        end
    endgenerate

    // reset_n gates the grant so nothing is issued while the block is held in reset
    assign any_valid = |s_valid;
    assign grant     = cke & any_valid & ~flush & reset_n;

    // Walk offsets from the far end back to rr_ptr so the nearest valid requester wins.
    always_comb begin
        logic [ID_BITS:0] sum;
        winner = '0;
        sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_reg} + (ID_BITS+1)'(k);
            if (sum >= (ID_BITS+1)'(NUM_REQ)) begin
                sum = sum - (ID_BITS+1)'(NUM_REQ);
            end
            if (s_valid[sum[ID_BITS-1:0]]) begin
                winner = sum[ID_BITS-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant) begin
            rr_ptr_next = (winner == ID_BITS'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= '0;
        end else if (cke) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign op_valid = grant;
    assign op_shift = grant ? shift_arr[winner] : '0;
    assign op_data  = grant ? data_arr[winner]  : '0;
    assign op_clear = flush;
    assign rsp_data = op_result;

    generate
        if (LATENCY == 0) begin : g_lat0
            assign rsp_valid = grant;
            assign rsp_id    = winner;
        end else begin : g_pipe
            logic               tag_v_reg  [LATENCY];
            logic [ID_BITS-1:0] tag_id_reg [LATENCY];

            // Flush kills every stage; stage 0 is already 0 because grant is blocked.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        tag_v_reg[k]  <= 1'b0;
                        tag_id_reg[k] <= '0;
                    end
                end else if (cke) begin
                    tag_v_reg[0]  <= grant;
                    tag_id_reg[0] <= winner;
                    for (int k = 1; k < LATENCY; k++) begin
                        tag_v_reg[k]  <= tag_v_reg[k-1] & ~flush;
                        tag_id_reg[k] <= tag_id_reg[k-1];
                    end
                end
            end

            assign rsp_valid = tag_v_reg[LATENCY-1];
            assign rsp_id    = tag_id_reg[LATENCY-1];
        end
    endgenerate

`ifdef ELIXIRCHIP_SPU_SRA_ARB_STATS_EN
    logic [31:0] stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (cke) begin
                    if (flush) begin
                        cnt_reg <= '0;
                    end else if (grant && (winner == ID_BITS'(gi))) begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
            end
            assign stat_grants[gi*32 +: 32] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
        end else if (cke) begin
            if (flush) begin
                stall_cnt_reg <= '0;
            end else if (any_valid && !grant) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign stat_stall = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_sra_arbiter.sv
// Directed bench: LATENCY=3 x4 arbiter driving a modelled 3-stage shifter, plus a
// LATENCY=0 x3 instance with a combinational shifter model.
module tb_elixirchip_es1_spu_sra_arbiter;

    logic         clk;
    logic         reset_n;
    logic         cke;
    logic         flush;

    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [19:0]  s_shift;
    logic [127:0] s_data;
    logic [4:0]   op_shift;
    logic [31:0]  op_data;
    logic         op_valid;
    logic         op_clear;
    logic [31:0]  op_result;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;

    logic [2:0]   s_valid0;
    logic [2:0]   s_ready0;
    logic [14:0]  s_shift0;
    logic [95:0]  s_data0;
    logic [4:0]   op_shift0;
    logic [31:0]  op_data0;
    logic         op_valid0;
    logic         op_clear0;
    logic [31:0]  op_result0;
    logic         rsp_valid0;
    logic [1:0]   rsp_id0;
    logic [31:0]  rsp_data0;

`ifdef ELIXIRCHIP_SPU_SRA_ARB_STATS_EN
    logic [127:0] stat_grants;
    logic [31:0]  stat_stall;
    logic [95:0]  stat_grants0;
    logic [31:0]  stat_stall0;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    elixirchip_es1_spu_sra_arbiter #(.NUM_REQ(4), .DATA_BITS(32), .LATENCY(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .cke(cke),
        .s_valid(s_valid), .s_ready(s_ready), .s_shift(s_shift), .s_data(s_data),
        .flush(flush), .op_shift(op_shift), .op_data(op_data), .op_valid(op_valid),
        .op_clear(op_clear), .op_result(op_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ELIXIRCHIP_SPU_SRA_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    elixirchip_es1_spu_sra_arbiter #(.NUM_REQ(3), .DATA_BITS(32), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cke(cke),
        .s_valid(s_valid0), .s_ready(s_ready0), .s_shift(s_shift0), .s_data(s_data0),
        .flush(flush), .op_shift(op_shift0), .op_data(op_data0), .op_valid(op_valid0),
        .op_clear(op_clear0), .op_result(op_result0),
        .rsp_valid(rsp_valid0), .rsp_id(rsp_id0), .rsp_data(rsp_data0)
`ifdef ELIXIRCHIP_SPU_SRA_ARB_STATS_EN
        , .stat_grants(stat_grants0), .stat_stall(stat_stall0)
`endif
    );

    // Shifter models: 3-stage cke-qualified pipe, and a combinational one for LATENCY=0
    logic [31:0] sh_pipe [3];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) sh_pipe[k] <= '0;
        end else if (cke) begin
            sh_pipe[0] <= $signed(op_data) >>> op_shift;
            sh_pipe[1] <= sh_pipe[0];
            sh_pipe[2] <= sh_pipe[1];
        end
    end
    assign op_result  = sh_pipe[2];
    assign op_result0 = $signed(op_data0) >>> op_shift0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [4:0] sh, input logic [31:0] d);
        s_shift[r*5 +: 5]  = sh;
        s_data[r*32 +: 32] = d;
    endtask

    logic [2:0]  pat0 [7];
    int          win0 [7];
    logic [31:0] exp_data0 [3];
    int          exp_cnt0 [3];

    initial begin
        reset_n  = 1'b0;
        cke      = 1'b1;
        flush    = 1'b0;
        s_valid  = 4'hF;
        s_shift  = '0;
        s_data   = '0;
        s_valid0 = '0;
        s_shift0 = '0;
        s_data0  = '0;

        // reset state
        #1;
        check_vec("rst_s_ready", 64'(s_ready), 64'h0);
        check_vec("rst_op_valid", 64'(op_valid), 64'h0);
        check_vec("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        s_valid = 4'h0;
        #11;
        reset_n = 1'b1;
        cycle();

        // 1: single request
        set_req(0, 5'd4, 32'h12345678);
        s_valid = 4'b0001;
        #1;
        check_vec("t1_s_ready", 64'(s_ready), 64'h1);
        check_vec("t1_op_shift", 64'(op_shift), 64'h4);
        check_vec("t1_op_data", 64'(op_data), 64'h12345678);
        cycle();
        s_valid = 4'b0000;
        #1;
        check_vec("t1_op_idle_data", 64'(op_data), 64'h0);
        cycle();
        check_vec("t1_rsp_early", 64'(rsp_valid), 64'h0);
        cycle();
        check_vec("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check_vec("t1_rsp_id", 64'(rsp_id), 64'h0);
        check_vec("t1_rsp_data", 64'(rsp_data), 64'h01234567);
        cycle();
        check_vec("t1_rsp_done", 64'(rsp_valid), 64'h0);

        // 2: fairness from reset
        reset_n = 1'b0;
        #4;
        reset_n = 1'b1;
        cycle();
        for (int r = 0; r < 4; r++) set_req(r, 5'(r + 1), 32'h8000_0000 >> r);
        for (int i = 0; i < 11; i++) begin
            s_valid = (i < 8) ? 4'hF : 4'h0;
            #1;
            if (i < 8) check_vec($sformatf("t2_s_ready_%0d", i), 64'(s_ready), 64'(4'b0001 << (i % 4)));
            check_vec($sformatf("t2_rsp_valid_%0d", i), 64'(rsp_valid), 64'((i >= 3) ? 1 : 0));
            if (i >= 3) check_vec($sformatf("t2_rsp_id_%0d", i), 64'(rsp_id), 64'((i - 3) % 4));
            cycle();
        end

        // 3: cke gap, then hold of a valid response
        set_req(1, 5'd8, 32'h87654321);
        s_valid = 4'b0010;
        #1;
        check_vec("t3_s_ready", 64'(s_ready), 64'h2);
        cycle();
        s_valid = 4'b0000;
        cke     = 1'b0;
        #1;
        check_vec("t3_rsp_frozen0", 64'(rsp_valid), 64'h0);
        cycle();
        s_valid = 4'b0100;
        #1;
        check_vec("t3_no_grant_cke0", 64'(s_ready), 64'h0);
        cycle();
        s_valid = 4'b0000;
        cke     = 1'b1;
        #1;
        check_vec("t3_rsp_wait1", 64'(rsp_valid), 64'h0);
        cycle();
        check_vec("t3_rsp_wait2", 64'(rsp_valid), 64'h0);
        cycle();
        check_vec("t3_rsp_valid", 64'(rsp_valid), 64'h1);
        check_vec("t3_rsp_id", 64'(rsp_id), 64'h1);
        check_vec("t3_rsp_data", 64'(rsp_data), 64'hff876543);
        cke = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_vec($sformatf("t3_hold_valid_%0d", i), 64'(rsp_valid), 64'h1);
            check_vec($sformatf("t3_hold_data_%0d", i), 64'(rsp_data), 64'hff876543);
        end
        cke = 1'b1;
        cycle();
        check_vec("t3_rsp_done", 64'(rsp_valid), 64'h0);

        // 4: flush with ops in flight (rr_ptr is 2 here)
        s_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_vec($sformatf("t4_grant_%0d", i), 64'(s_ready), 64'(4'b0001 << ((i + 2) % 4)));
            cycle();
        end
        flush = 1'b1;
        #1;
        check_vec("t4_flush_s_ready", 64'(s_ready), 64'h0);
        check_vec("t4_flush_op_valid", 64'(op_valid), 64'h0);
        check_vec("t4_op_clear", 64'(op_clear), 64'h1);
        cycle();
        flush   = 1'b0;
        s_valid = 4'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_vec($sformatf("t4_dropped_%0d", i), 64'(rsp_valid), 64'h0);
            cycle();
        end
        s_valid = 4'hF;
        #1;
        check_vec("t4_next_grant", 64'(s_ready), 64'h2);
        cycle();
        s_valid = 4'h0;
        cycle();
        cycle();
        check_vec("t4_rsp_valid", 64'(rsp_valid), 64'h1);
        check_vec("t4_rsp_id", 64'(rsp_id), 64'h1);
        check_vec("t4_rsp_data", 64'(rsp_data), 64'hff876543);
        cycle();

        // 5: reset with the pipe full (rr_ptr is 2 here)
        s_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_vec($sformatf("t5_grant_%0d", i), 64'(s_ready), 64'(4'b0001 << ((i + 2) % 4)));
            cycle();
        end
        check_vec("t5_pipe_out", 64'(rsp_valid), 64'h1);
        check_vec("t5_pipe_id", 64'(rsp_id), 64'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("t5_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check_vec("t5_rst_s_ready", 64'(s_ready), 64'h0);
        check_vec("t5_rst_op_valid", 64'(op_valid), 64'h0);
        s_valid = 4'b1001;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_vec("t5_first_grant", 64'(s_ready), 64'h1);
        cycle();
        s_valid = 4'h0;
        cycle();

        // 6: LATENCY=0 instance, NUM_REQ=3
        pat0[0] = 3'b111; win0[0] = 0;
        pat0[1] = 3'b111; win0[1] = 1;
        pat0[2] = 3'b101; win0[2] = 2;
        pat0[3] = 3'b110; win0[3] = 1;
        pat0[4] = 3'b011; win0[4] = 0;
        pat0[5] = 3'b000; win0[5] = -1;
        pat0[6] = 3'b100; win0[6] = 2;
        exp_data0[0] = 32'hC000_0000;
        exp_data0[1] = 32'h0000_0000;
        exp_data0[2] = 32'hFF00_0000;
        s_shift0 = {5'd4, 5'd31, 5'd1};
        s_data0  = {32'hF000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        for (int r = 0; r < 3; r++) exp_cnt0[r] = 0;
        for (int i = 0; i < 7; i++) begin
            s_valid0 = pat0[i];
            #1;
            check_vec($sformatf("t6_rsp_eq_op_%0d", i), 64'(rsp_valid0), 64'(op_valid0));
            if (win0[i] < 0) begin
                check_vec($sformatf("t6_idle_%0d", i), 64'({rsp_valid0, s_ready0}), 64'h0);
            end else begin
                exp_cnt0[win0[i]]++;
                check_vec($sformatf("t6_s_ready_%0d", i), 64'(s_ready0), 64'(3'b001 << win0[i]));
                check_vec($sformatf("t6_rsp_valid_%0d", i), 64'(rsp_valid0), 64'h1);
                check_vec($sformatf("t6_rsp_id_%0d", i), 64'(rsp_id0), 64'(win0[i]));
                check_vec($sformatf("t6_rsp_data_%0d", i), 64'(rsp_data0), 64'(exp_data0[win0[i]]));
            end
            cycle();
        end
        s_valid0 = '0;
`ifdef ELIXIRCHIP_SPU_SRA_ARB_STATS_EN
        for (int r = 0; r < 3; r++)
            check_vec($sformatf("t6_stat_grants_%0d", r), 64'(stat_grants0[r*32 +: 32]), 64'(exp_cnt0[r]));
        check_vec("t6_stat_stall", 64'(stat_stall0), 64'h0);
`endif
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
